// File: rtl/nn_dnode_wb_acc.sv
// ============================================================================
// nn_dnode_wb_acc : stochastic backprop weight/bias gradient node with windowed
//                   saturating integration and valid/ready result hand-off.
// Rev 1.0
// ============================================================================
`default_nettype none

module nn_dnode_wb_acc #(
  parameter int NB        = 16,
  parameter int NN        = 3,
  parameter int WIN_LOG   = 8,
  parameter int BIAS_MODE = 0
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             EN,
  input  logic             delta_p,
  input  logic             delta_n,
  input  logic [NN-1:0]    atj,
  output logic [NN-1:0]    dalpha_p,
  output logic [NN-1:0]    dalpha_n,
  output logic             dbeta_p,
  output logic             dbeta_n,
  output logic [NN*NB-1:0] grad_alpha,
  output logic [NB-1:0]    grad_beta,
  output logic             grad_valid,
  input  logic             grad_ready,
  output logic             drop
);

  localparam logic signed [NB-1:0] SAT_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0] SAT_MIN = {1'b1, {(NB-2){1'b0}}, 1'b1};
  localparam logic signed [NB-1:0] ONE     = {{(NB-1){1'b0}}, 1'b1};

  logic               bias_in;
  logic [NN:0]        src;
  logic [WIN_LOG-1:0] cnt;
  logic               win_end;
  logic signed [NB-1:0] acc     [NN+1];
  logic signed [NB-1:0] acc_nxt [NN+1];

  assign bias_in = (BIAS_MODE == 1) ? 1'b1 : (|atj);
  // Index NN is the bias accumulator; 0..NN-1 are the weights.
  assign src     = {bias_in, atj};
  assign win_end = EN & (&cnt);

  always_comb begin
    for (int i = 0; i <= NN; i++) begin
      acc_nxt[i] = acc[i];
      if (EN && src[i] && (delta_p != delta_n)) begin
        if (delta_p && (acc[i] != SAT_MAX))
          acc_nxt[i] = acc[i] + ONE;
        else if (delta_n && (acc[i] != SAT_MIN))
          acc_nxt[i] = acc[i] - ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      dalpha_p   <= '0;
      dalpha_n   <= '0;
      dbeta_p    <= 1'b0;
      dbeta_n    <= 1'b0;
      cnt        <= '0;
      grad_alpha <= '0;
      grad_beta  <= '0;
      grad_valid <= 1'b0;
      drop       <= 1'b0;
      for (int i = 0; i <= NN; i++) acc[i] <= '0;
    end else begin
      dalpha_p <= atj & {NN{delta_p}};
      dalpha_n <= atj & {NN{delta_n}};
      dbeta_p  <= delta_p & bias_in;
      dbeta_n  <= delta_n & bias_in;
      if (EN) cnt <= cnt + 1'b1;
      if (win_end) begin
        for (int n = 0; n < NN; n++) grad_alpha[n*NB +: NB] <= acc_nxt[n];
        grad_beta  <= acc_nxt[NN];
        grad_valid <= 1'b1;
        if (grad_valid && !grad_ready) drop <= 1'b1;
        for (int i = 0; i <= NN; i++) acc[i] <= '0;
      end else begin
        for (int i = 0; i <= NN; i++) acc[i] <= acc_nxt[i];
        if (grad_ready) grad_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nn_dnode_wb_acc.sv
// Bench for nn_dnode_wb_acc: three instances (NB=16, NB=4, BIAS_MODE=1) on shared
// stimulus, checked each cycle against an integer model plus literal expectations.
`default_nettype none

module tb_nn_dnode_wb_acc;

  logic       CLK = 1'b0;
  logic       INIT = 1'b0;
  logic       EN = 1'b0;
  logic       delta_p = 1'b0;
  logic       delta_n = 1'b0;
  logic [2:0] atj = 3'b000;
  logic       grad_ready = 1'b0;

  logic [2:0]  dap0, dan0, dap1, dan1, dap2, dan2;
  logic        dbp0, dbn0, dbp1, dbn1, dbp2, dbn2;
  logic [47:0] ga0, ga2;
  logic [11:0] ga1;
  logic [15:0] gb0, gb2;
  logic [3:0]  gb1;
  logic        gv0, gv1, gv2, dr0, dr1, dr2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  nn_dnode_wb_acc #(.NB(16), .NN(3), .WIN_LOG(4), .BIAS_MODE(0)) u0 (
    .CLK(CLK), .INIT(INIT), .EN(EN), .delta_p(delta_p), .delta_n(delta_n), .atj(atj),
    .dalpha_p(dap0), .dalpha_n(dan0), .dbeta_p(dbp0), .dbeta_n(dbn0),
    .grad_alpha(ga0), .grad_beta(gb0), .grad_valid(gv0), .grad_ready(grad_ready), .drop(dr0));

  nn_dnode_wb_acc #(.NB(4), .NN(3), .WIN_LOG(4), .BIAS_MODE(0)) u1 (
    .CLK(CLK), .INIT(INIT), .EN(EN), .delta_p(delta_p), .delta_n(delta_n), .atj(atj),
    .dalpha_p(dap1), .dalpha_n(dan1), .dbeta_p(dbp1), .dbeta_n(dbn1),
    .grad_alpha(ga1), .grad_beta(gb1), .grad_valid(gv1), .grad_ready(grad_ready), .drop(dr1));

  nn_dnode_wb_acc #(.NB(16), .NN(3), .WIN_LOG(4), .BIAS_MODE(1)) u2 (
    .CLK(CLK), .INIT(INIT), .EN(EN), .delta_p(delta_p), .delta_n(delta_n), .atj(atj),
    .dalpha_p(dap2), .dalpha_n(dan2), .dbeta_p(dbp2), .dbeta_n(dbn2),
    .grad_alpha(ga2), .grad_beta(gb2), .grad_valid(gv2), .grad_ready(grad_ready), .drop(dr2));

  // Model state: running window sums, published results, flags, expected streams.
  int lim [3] = '{32767, 7, 32767};
  int sum [3][4];
  int g   [3][4];
  int gv  [3];
  int dr  [3];
  int ebp [3];
  int ebn [3];
  int eap, ean;
  int wcnt;

  always @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 4; j++) begin sum[k][j] = 0; g[k][j] = 0; end
        gv[k] = 0; dr[k] = 0; ebp[k] = 0; ebn[k] = 0;
      end
      eap = 0; ean = 0; wcnt = 0;
    end else begin
      eap = delta_p ? int'(atj) : 0;
      ean = delta_n ? int'(atj) : 0;
      for (int k = 0; k < 3; k++) begin
        int b;
        b = (k == 2) ? 1 : ((atj != 3'b000) ? 1 : 0);
        ebp[k] = delta_p ? b : 0;
        ebn[k] = delta_n ? b : 0;
        if (EN) begin
          for (int j = 0; j < 4; j++) begin
            int x;
            x = (j < 3) ? int'(atj[j]) : b;
            sum[k][j] += (delta_p ? x : 0) - (delta_n ? x : 0);
            if (sum[k][j] > lim[k])  sum[k][j] = lim[k];
            if (sum[k][j] < -lim[k]) sum[k][j] = -lim[k];
          end
        end
      end
      if (EN && wcnt == 15) begin
        for (int k = 0; k < 3; k++) begin
          if (gv[k] != 0 && !grad_ready) dr[k] = 1;
          for (int j = 0; j < 4; j++) begin g[k][j] = sum[k][j]; sum[k][j] = 0; end
          gv[k] = 1;
        end
        wcnt = 0;
      end else begin
        if (grad_ready) for (int k = 0; k < 3; k++) gv[k] = 0;
        if (EN) wcnt++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input int a0, input int a1, input int a2, input int b,
                          input int v, input int d, input int dap, input int dan,
                          input int dbp, input int dbn);
    chk($sformatf("u%0d.alpha0", k), a0, g[k][0]);
    chk($sformatf("u%0d.alpha1", k), a1, g[k][1]);
    chk($sformatf("u%0d.alpha2", k), a2, g[k][2]);
    chk($sformatf("u%0d.beta", k), b, g[k][3]);
    chk($sformatf("u%0d.valid", k), v, gv[k]);
    chk($sformatf("u%0d.drop", k), d, dr[k]);
    chk($sformatf("u%0d.dalpha_p", k), dap, eap);
    chk($sformatf("u%0d.dalpha_n", k), dan, ean);
    chk($sformatf("u%0d.dbeta_p", k), dbp, ebp[k]);
    chk($sformatf("u%0d.dbeta_n", k), dbn, ebn[k]);
  endtask

  always @(negedge CLK) begin
    cmp_inst(0, $signed(ga0[15:0]), $signed(ga0[31:16]), $signed(ga0[47:32]), $signed(gb0),
             int'(gv0), int'(dr0), int'(dap0), int'(dan0), int'(dbp0), int'(dbn0));
    cmp_inst(1, $signed(ga1[3:0]), $signed(ga1[7:4]), $signed(ga1[11:8]), $signed(gb1),
             int'(gv1), int'(dr1), int'(dap1), int'(dan1), int'(dbp1), int'(dbn1));
    cmp_inst(2, $signed(ga2[15:0]), $signed(ga2[31:16]), $signed(ga2[47:32]), $signed(gb2),
             int'(gv2), int'(dr2), int'(dap2), int'(dan2), int'(dbp2), int'(dbn2));
  end

  // Apply inputs now, hold for n rising edges, return 1 time unit after the last edge.
  task automatic cyc(input logic en, input logic dp, input logic dn, input logic [2:0] a,
                     input logic rdy, input int n);
    EN = en; delta_p = dp; delta_n = dn; atj = a; grad_ready = rdy;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    INIT = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.valid", int'(gv0), 0);
    chk("reset.alpha", int'(ga0), 0);
    INIT = 1'b0;

    // Positive delta on atj=101
    cyc(1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1);
    chk("t2.dalpha_p", int'(dap0), 5);
    cyc(1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 14);
    chk("t2.valid_early", int'(gv0), 0);
    cyc(1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1);
    chk("t2.valid", int'(gv0), 1);
    chk("t2.alpha0", $signed(ga0[15:0]), 16);
    chk("t2.alpha1", $signed(ga0[31:16]), 0);
    chk("t2.alpha2", $signed(ga0[47:32]), 16);
    chk("t2.beta", $signed(gb0), 16);
    chk("t5.sat_pos", $signed(ga1[3:0]), 7);

    // Negative delta on atj=010, then both signs together
    cyc(1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 16);
    chk("t3.alpha1", int'(ga0[31:16]), 32'h0000FFF0);
    chk("t3.beta", $signed(gb0), -16);
    chk("t5.sat_neg", $signed(ga1[7:4]), -7);
    chk("t3.drop", int'(dr0), 0);
    cyc(1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 16);
    chk("t3.both_alpha", int'(ga0), 0);
    chk("t3.both_beta", int'(gb0), 0);

    // Alternating EN doubles the window length
    cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1);
    chk("t4.cleared", int'(gv0), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1);
      if (i == 14) chk("t4.valid_early", int'(gv0), 0);
      cyc(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1);
    end
    chk("t4.valid", int'(gv0), 1);
    chk("t4.alpha0", $signed(ga0[15:0]), 16);
    chk("t4.alpha2", $signed(ga0[47:32]), 16);
    chk("t4.beta", $signed(gb0), 16);

    // Overrun: second window while unaccepted
    cyc(1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 16);
    chk("t6.drop", int'(dr0), 1);
    chk("t6.valid", int'(gv0), 1);
    chk("t6.alpha0", $signed(ga0[15:0]), 16);
    chk("t6.alpha1", $signed(ga0[31:16]), 0);
    cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1);
    chk("t6.valid_fall", int'(gv0), 0);
    chk("t6.drop_sticky", int'(dr0), 1);

    // Constant-1 bias input
    cyc(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 16);
    chk("t6.bias_mode1_beta", $signed(gb2), 16);
    chk("t6.bias_mode1_alpha", int'(ga2), 0);
    chk("t6.bias_mode0_beta", $signed(gb0), 0);

    // Mid-window reset with drop and valid set
    cyc(1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 7);
    chk("t1.pre_valid", int'(gv0), 1);
    chk("t1.pre_drop", int'(dr0), 1);
    INIT = 1'b1;
    #1;
    chk("t1.valid0", int'(gv0), 0);
    chk("t1.drop0", int'(dr0), 0);
    chk("t1.alpha0", int'(ga0), 0);
    chk("t1.dalpha0", int'(dap0), 0);
    repeat (2) @(posedge CLK);
    #1;
    INIT = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 15);
    chk("t1.no_early_valid", int'(gv0), 0);
    cyc(1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1);
    chk("t1.valid_after", int'(gv0), 1);
    chk("t1.alpha_after", $signed(ga0[15:0]), 16);

    cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
